// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   generate
      if (WIDTH < 1 || DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
          AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_check
         $error("sync_fifo_flags: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    occ;
   logic             rd_ok;
   logic             wr_ok;

   assign empty        = (occ == '0);
   assign full         = (occ == CW'(DEPTH));
   assign almost_full  = (occ >= CW'(AF_LEVEL));
   assign almost_empty = (occ <= CW'(AE_LEVEL));
   assign count        = occ;

   // A read in the same cycle frees a slot, so a full FIFO can still accept a write.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   // Pointers wrap by explicit compare so non-power-of-two depths work.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         occ       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok)
            wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
         if (rd_ok)
            rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
         if (wr_en & ~wr_ok)
            overflow <= 1'b1;
         if (rd_en & empty)
            underflow <= 1'b1;
      end
   end

   // Storage is never cleared; a write coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok)
         mem[wptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem[rptr];
      end else begin : g_std
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (reset)
               dout_q <= '0;
            else if (rd_ok)
               dout_q <= mem[rptr];
         end
         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: three instances (standard, depth-3 wrap, FWFT)
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
   logic [31:0] din0 = '0;
   logic [7:0]  din1 = '0;
   logic [15:0] din2 = '0;

   logic [31:0] dout0;
   logic [7:0]  dout1;
   logic [15:0] dout2;
   logic        full0, empty0, af0, ae0, ovf0, udf0;
   logic        full1, empty1, af1, ae1, ovf1, udf1;
   logic        full2, empty2, af2, ae2, ovf2, udf2;
   logic [2:0]  cnt0;
   logic [1:0]  cnt1;
   logic [2:0]  cnt2;

   sync_fifo_flags #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_dut0 (
      .clk(clk), .reset(reset), .wr_en(wr0), .data_in(din0), .rd_en(rd0),
      .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
      .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

   sync_fifo_flags #(.WIDTH(8), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(0)) u_dut1 (
      .clk(clk), .reset(reset), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
      .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
      .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

   sync_fifo_flags #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(2), .AE_LEVEL(0), .FWFT(1)) u_dut2 (
      .clk(clk), .reset(reset), .wr_en(wr2), .data_in(din2), .rd_en(rd2),
      .data_out(dout2), .full(full2), .empty(empty2), .almost_full(af2),
      .almost_empty(ae2), .count(cnt2), .overflow(ovf2), .underflow(udf2));

   int checks = 0;
   int failures = 0;

   // Reference model: per-instance queue plus registered output and sticky flags.
   int          dep  [3] = '{4, 3, 4};
   int          afl  [3] = '{3, 2, 2};
   int          ael  [3] = '{1, 1, 0};
   int          fw   [3] = '{0, 0, 1};
   logic [31:0] msk  [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FFFF};
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];
   logic [31:0] mdout [3] = '{0, 0, 0};
   bit          movf  [3] = '{0, 0, 0};
   bit          mudf  [3] = '{0, 0, 0};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelUpdate(ref logic [31:0] q[$], input int d, input bit w, input bit r,
                              input logic [31:0] di);
      int sz;
      bit rok, wok;
      sz  = q.size();
      rok = r && (sz > 0);
      wok = w && ((sz < dep[d]) || rok);
      if (w && !wok) movf[d] = 1'b1;
      if (r && sz == 0) mudf[d] = 1'b1;
      if (rok) mdout[d] = q.pop_front();
      if (wok) q.push_back(di & msk[d]);
   endtask

   function automatic int msize(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [31:0] mfront(input int d);
      if (msize(d) == 0) return '0;
      case (d)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic compareAll(input int d);
      logic [31:0] o_dout, o_cnt;
      logic        o_full, o_empty, o_af, o_ae, o_ovf, o_udf;
      int          sz;
      logic [31:0] e_dout;
      case (d)
         0: begin
            o_dout = dout0; o_cnt = 32'(cnt0); o_full = full0; o_empty = empty0;
            o_af = af0; o_ae = ae0; o_ovf = ovf0; o_udf = udf0;
         end
         1: begin
            o_dout = 32'(dout1); o_cnt = 32'(cnt1); o_full = full1; o_empty = empty1;
            o_af = af1; o_ae = ae1; o_ovf = ovf1; o_udf = udf1;
         end
         default: begin
            o_dout = 32'(dout2); o_cnt = 32'(cnt2); o_full = full2; o_empty = empty2;
            o_af = af2; o_ae = ae2; o_ovf = ovf2; o_udf = udf2;
         end
      endcase
      sz     = msize(d);
      e_dout = (fw[d] != 0) ? mfront(d) : mdout[d];
      checkOutput($sformatf("d%0d_count", d), o_cnt, 32'(sz));
      checkOutput($sformatf("d%0d_full", d), 32'(o_full), 32'(sz == dep[d]));
      checkOutput($sformatf("d%0d_empty", d), 32'(o_empty), 32'(sz == 0));
      checkOutput($sformatf("d%0d_almost_full", d), 32'(o_af), 32'(sz >= afl[d]));
      checkOutput($sformatf("d%0d_almost_empty", d), 32'(o_ae), 32'(sz <= ael[d]));
      checkOutput($sformatf("d%0d_overflow", d), 32'(o_ovf), 32'(movf[d]));
      checkOutput($sformatf("d%0d_underflow", d), 32'(o_udf), 32'(mudf[d]));
      checkOutput($sformatf("d%0d_data_out", d), o_dout, e_dout);
   endtask

   // One clock of stimulus to instance d, then model update and full comparison.
   task automatic applyStimulus(input int d, input bit w, input bit r, input logic [31:0] di,
                                input bit rst = 1'b0);
      case (d)
         0:       begin wr0 = w; rd0 = r; din0 = di; end
         1:       begin wr1 = w; rd1 = r; din1 = di[7:0]; end
         default: begin wr2 = w; rd2 = r; din2 = di[15:0]; end
      endcase
      reset = rst;
      @(posedge clk);
      #1;
      wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0; wr2 = 0; rd2 = 0; reset = 0;
      if (rst) begin
         q0.delete(); q1.delete(); q2.delete();
         for (int k = 0; k < 3; k++) begin
            mdout[k] = '0; movf[k] = 0; mudf[k] = 0;
         end
      end else begin
         case (d)
            0:       modelUpdate(q0, 0, w, r, di);
            1:       modelUpdate(q1, 1, w, r, di);
            default: modelUpdate(q2, 2, w, r, di);
         endcase
      end
      compareAll(d);
   endtask

   initial begin
      logic [31:0] fillv [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

      // Reset and fill to full, then overflow
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("reset_empty", 32'(empty0), 32'd1);
      checkOutput("reset_almost_empty", 32'(ae0), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 0, fillv[i]);
         checkOutput($sformatf("fill_count%0d", i), 32'(cnt0), 32'(i + 1));
      end
      checkOutput("fill_full", 32'(full0), 32'd1);
      applyStimulus(0, 1, 0, 32'h55);
      checkOutput("fill_overflow", 32'(ovf0), 32'd1);
      checkOutput("fill_count_hold", 32'(cnt0), 32'd4);

      // Drain with one extra read
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 0);
         checkOutput($sformatf("drain_data%0d", i), dout0, fillv[i]);
      end
      applyStimulus(0, 0, 1, 0);
      checkOutput("drain_underflow", 32'(udf0), 32'd1);
      checkOutput("drain_hold", dout0, 32'h44);

      // Simultaneous read+write at full and at empty
      applyStimulus(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, fillv[i]);
      applyStimulus(0, 1, 1, 32'h66);
      checkOutput("full_rw_count", 32'(cnt0), 32'd4);
      checkOutput("full_rw_no_overflow", 32'(ovf0), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);
      checkOutput("full_rw_last", dout0, 32'h66);
      applyStimulus(0, 1, 1, 32'h77);
      checkOutput("empty_rw_count", 32'(cnt0), 32'd1);
      checkOutput("empty_rw_underflow", 32'(udf0), 32'd1);
      checkOutput("empty_rw_hold", dout0, 32'h66);

      // Reset mid-operation with count=3 and overflow set
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h100 + 32'(i));
      applyStimulus(0, 0, 1, 0);
      checkOutput("premid_count", 32'(cnt0), 32'd3);
      checkOutput("premid_overflow", 32'(ovf0), 32'd1);
      applyStimulus(0, 1, 0, 32'h99, 1);
      checkOutput("mid_reset_count", 32'(cnt0), 32'd0);
      checkOutput("mid_reset_overflow", 32'(ovf0), 32'd0);
      checkOutput("mid_reset_dout", dout0, 32'd0);
      applyStimulus(0, 1, 0, 32'hBEEF);
      applyStimulus(0, 0, 1, 0);
      checkOutput("post_reset_data", dout0, 32'hBEEF);

      // Depth-3 streaming at occupancy 1 across pointer wrap
      applyStimulus(1, 1, 0, 32'h0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1, 1, 1, 32'(i));
         checkOutput($sformatf("wrap_data%0d", i - 1), 32'(dout1), 32'(i - 1));
      end
      applyStimulus(1, 0, 1, 0);

      // FWFT visibility and pop
      applyStimulus(2, 1, 0, 32'hA5);
      checkOutput("fwft_empty", 32'(empty2), 32'd0);
      checkOutput("fwft_data", 32'(dout2), 32'hA5);
      applyStimulus(2, 0, 1, 0);
      checkOutput("fwft_pop_empty", 32'(empty2), 32'd1);
      checkOutput("fwft_pop_data", 32'(dout2), 32'd0);

      // Random traffic on each instance against the model
      applyStimulus(0, 0, 0, 0, 1);
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 300; n++) begin
            applyStimulus(d, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                          $urandom & msk[d]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
